asmd_bin2bcd: RTL and testbench

//  Downstream stage of the decimator datapath. Consumes the 16-bit result word the

---
 rtl/asmd_bin2bcd.sv | 112 +++++++++++
 tb/tb_asmd_bin2bcd.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/asmd_bin2bcd.sv
// Binary to packed BCD converter using a shift-add-3 (double-dabble) ASMD controller.
// Each input bit takes two cycles: an adjust cycle followed by a shift cycle.
module asmd_bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      Bin,
    input  logic                  Start,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADJ,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  sh_q;
    logic [BW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bcd_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic [BW-1:0]     acc_adj_d;
    logic [BW-1:0]     acc_shift_d;
    logic [WIDTH-1:0]  sh_shift_d;
    logic [CW-1:0]     cnt_dec_d;

    // Every digit is corrected independently so the next shift carries cleanly into the digit above.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign acc_adj_d[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                          (acc_q[4*gi +: 4] + 4'd3) : acc_q[4*gi +: 4];
        end
    endgenerate

    assign acc_shift_d = {acc_q[BW-2:0], sh_q[WIDTH-1]};
    assign sh_shift_d  = {sh_q[WIDTH-2:0], 1'b0};
    assign cnt_dec_d   = cnt_q - CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        sh_q    <= Bin;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= S_ADJ;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ADJ: begin
                    acc_q   <= acc_adj_d;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc_q <= acc_shift_d;
                    sh_q  <= sh_shift_d;
                    cnt_q <= cnt_dec_d;
                    if (cnt_dec_d == '0) begin
                        bcd_q   <= acc_shift_d;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ADJ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Ready = ready_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign BCD   = bcd_q;

endmodule

// File: tb/tb_asmd_bin2bcd.sv
// Self-checking bench for asmd_bin2bcd: vector table, randomized values against a
// decimal reference model, and hand-written sequences for the multi-cycle corner cases.
module tb_asmd_bin2bcd;

    logic        clk;
    logic        rst;
    logic [15:0] Bin;
    logic        Start;
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic [19:0] BCD;

    int total = 0;
    int bad   = 0;

    asmd_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .Bin   (Bin),
        .Start (Start),
        .Ready (Ready),
        .Busy  (Busy),
        .Done  (Done),
        .BCD   (BCD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, independent of any shifting scheme.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One conversion: load at an edge, Done expected 32 edges later (2 cycles per bit).
    task automatic run_conv(input logic [15:0] b, input logic [19:0] exp, input string name);
        int n;
        int busy_n;
        bit seen;
        n = 0;
        while (!Ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        chk({name, "_ready"}, 32'(Ready), 32'd1);
        Bin   = b;
        Start = 1'b1;
        @(posedge clk); #1;
        Start  = 1'b0;
        busy_n = Busy ? 1 : 0;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (Busy) busy_n++;
            if (Done) seen = 1'b1;
        end
        chk({name, "_latency"}, seen ? 32'(n) : 32'hDEAD, 32'd32);
        chk({name, "_bcd"}, 32'(BCD), 32'(exp));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'd32);
        @(posedge clk); #1;
        chk({name, "_done_one_cycle"}, 32'(Done), 32'd0);
        chk({name, "_ready_after"}, 32'(Ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_bcd_hold"}, 32'(BCD), 32'(exp));
        $display("conv %s: Bin=%0d BCD=%05h latency=%0d", name, b, BCD, n);
    endtask

    initial begin
        int n;
        int dones;
        int d_edge[2];
        logic [19:0] d_bcd[2];
        logic [15:0] r;
        logic [15:0] b1;

        vecs[0] = '{16'h0000, 20'h00000};
        vecs[1] = '{16'hFFFF, 20'h65535};
        vecs[2] = '{16'h270F, 20'h09999};
        vecs[3] = '{16'h0080, 20'h00128};
        vecs[4] = '{16'd1000, 20'h01000};
        vecs[5] = '{16'd42,   20'h00042};
        vecs[6] = '{16'd9,    20'h00009};
        vecs[7] = '{16'd10,   20'h00010};
        vecs[8] = '{16'd99999 % 65536, 20'h34463};
        vecs[9] = '{16'd50000, 20'h50000};

        rst   = 1'b1;
        Start = 1'b0;
        Bin   = '0;
        @(posedge clk); #1;
        chk("reset_ready", 32'(Ready), 32'd1);
        chk("reset_busy",  32'(Busy),  32'd0);
        chk("reset_done",  32'(Done),  32'd0);
        chk("reset_bcd",   32'(BCD),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset: Ready=%0b Busy=%0b Done=%0b BCD=%05h", Ready, Busy, Done, BCD);

        for (int i = 0; i < 10; i++)
            run_conv(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            r = 16'($urandom);
            run_conv(r, ref_bcd(32'(r)), $sformatf("rand%0d", i));
        end

        // Start pulses and Bin changes while busy must not disturb the running conversion.
        b1 = 16'd31415;
        @(negedge clk);
        Bin = b1; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        dones = 0;
        d_bcd[0] = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            Bin   = 16'($urandom);
            Start = (k < 29) ? 1'($urandom % 2) : 1'b0;
            @(posedge clk); #1;
            if (Done) begin
                dones++;
                d_bcd[0] = BCD;
            end
        end
        Start = 1'b0;
        chk("ignore_start_dones", 32'(dones), 32'd1);
        chk("ignore_start_bcd", 32'(d_bcd[0]), 32'(ref_bcd(32'(b1))));
        $display("ignore_start: dones=%0d BCD=%05h", dones, d_bcd[0]);

        // Start held high: back-to-back conversions, results 34 cycles apart.
        @(negedge clk);
        Bin = 16'd1000; Start = 1'b1;
        @(posedge clk); #1;
        n = 0; dones = 0;
        d_edge[0] = -1; d_edge[1] = -1;
        d_bcd[1] = '0;
        @(negedge clk);
        Bin = 16'd42;
        while (dones < 2 && n < 80) begin
            @(posedge clk); #1;
            n++;
            if (Done) begin
                d_edge[dones] = n;
                d_bcd[dones]  = BCD;
                dones++;
            end
        end
        Start = 1'b0;
        chk("held_dones", 32'(dones), 32'd2);
        chk("held_first_edge", 32'(d_edge[0]), 32'd32);
        chk("held_spacing", 32'(d_edge[1] - d_edge[0]), 32'd34);
        chk("held_bcd0", 32'(d_bcd[0]), 32'h01000);
        chk("held_bcd1", 32'(d_bcd[1]), 32'h00042);
        $display("held_start: done edges %0d,%0d BCD %05h,%05h", d_edge[0], d_edge[1], d_bcd[0], d_bcd[1]);
        repeat (40) @(posedge clk);

        // Reset mid-conversion discards the work in progress.
        @(negedge clk);
        Bin = 16'd54321; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(Ready), 32'd1);
        chk("midrst_busy",  32'(Busy),  32'd0);
        chk("midrst_bcd",   32'(BCD),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        chk("midrst_bcd_stays", 32'(BCD), 32'd0);
        $display("mid_reset: dones=%0d BCD=%05h", dones, BCD);
        run_conv(16'd777, 20'h00777, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
